muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle integer multiply/divide unit with HI/LO result registers for the MIPS datapath.
//  Replaces the combinational mult/multu/div/divu ALU ops with a parametrised iterative engine.
//  Provides a start/busy/done handshake so the controller can stall until a result is ready.
//  Sits beside the ALU. Results feed mfhi/mflo via the hi/lo ports.
// PARAMETERS
//  WIDTH  32  operand width in bits; hi and lo are each WIDTH bits (WIDTH >= 4, even)
// PORTS
//  clk      in   1      single clock; all state updates on its rising edge
//  reset_n  in   1      synchronous, active-low reset
//  start    in   1      request; accepted only when ready=1
//  op       in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved
//  a        in   WIDTH  rs operand (multiplicand / dividend / mthi-mtlo source)
//  b        in   WIDTH  rt operand (multiplier / divisor)
//  ready    out  1      1 in IDLE or DONE; start is accepted
//  busy     out  1      1 in CALC or FIX
//  done     out  1      one-cycle pulse when hi/lo hold a new result
//  dbz      out  1      divide-by-zero flag, valid with done, held until the next accept
//  hi       out  WIDTH  HI register (mult: upper product; div: remainder)
//  lo       out  WIDTH  LO register (mult: lower product; div: quotient)
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): state=IDLE, hi=lo=0, busy=done=dbz=0, ready=1.
//   Reset aborts any operation in flight. hi/lo take no partial result.
//  FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   DONE behaves like IDLE, except done=1.
//  Accept: edge where start=1 and ready=1. a, b and op are latched. dbz is cleared.
//  MULT/MULTU/DIV/DIVU: accept edge -> CALC.
//   CALC runs exactly WIDTH edges, one bit per edge (shift-add multiply / restoring divide).
//   Then FIX for one edge: sign correction, and hi/lo are written on that edge -> DONE.
//   done=1 for one cycle. Accept-to-done latency is WIDTH+2 edges (34 for WIDTH=32).
//  Signed ops work on magnitudes.
//   Product is negated if the operand signs differ.
//   Quotient is negated if the signs differ.
//   Remainder takes the sign of the dividend.
//  Unsigned ops produce the full 2*WIDTH product. No truncation.
//  Divide by zero (b=0, DIV or DIVU): latency and flow are unchanged.
//   Result: lo = all ones, hi = a. dbz=1 together with done.
//  Signed overflow (DIV, a = 100..0, b = all ones): lo = 100..0, hi = 0. dbz=0.
//  MTHI/MTLO: hi (resp. lo) = a on the accept edge. The other register is unchanged.
//   Next state is DONE, so done pulses on the following cycle. busy is never asserted.
//  Reserved op: accepted and discarded. State stays/returns to IDLE. No done, hi/lo unchanged.
//  start while busy=1 is ignored. It is not queued.
//   An accept in DONE starts back-to-back work. The done pulse for the previous op still occurs.
//  hi/lo change only on a FIX edge, an MTHI/MTLO accept, or reset. They are stable otherwise.
// TESTING
//  1. MULT a=FFFFFFFD, b=00000005 -> done exactly 34 cycles after accept; hi=FFFFFFFF, lo=FFFFFFF1.
//  2. MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; busy high for 33 cycles.
//  3. DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//     DIVU a=7, b=0 -> lo=FFFFFFFF, hi=00000007, dbz=1.
//  4. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000, dbz=0.
//  5. MULTU 6*7 started; reset_n=0 at cycle 10, and a second start issued at cycle 5 ->
//     second start ignored; after reset hi=lo=0, no done pulse.
//  6. WIDTH=8: MTLO a=5A, then DIVU a=C8, b=0A back-to-back from DONE ->
//     lo=5A after the first done; after the second done (10 cycles after accept) lo=14, hi=00.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One result bit per cycle; sign fix-up and HI/LO write in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state;

  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               zero_b;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   mb;
  logic [WIDTH-1:0]   q;
  logic [WIDTH:0]     acc;

  logic               accept;
  logic               sgn_op;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign ready  = (state == IDLE) || (state == DONE);
  assign busy   = (state == CALC) || (state == FIX);
  assign done   = (state == DONE);
  assign accept = start & ready;

  // MULT and DIV have op[0]=0; signed ops run on magnitudes
  assign sgn_op = ~op[0];
  assign abs_a  = (sgn_op && a[WIDTH-1]) ? -a : a;
  assign abs_b  = (sgn_op && b[WIDTH-1]) ? -b : b;

  assign add_sum = acc + (q[0] ? {1'b0, mb} : '0);
  assign shl     = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign trial   = shl - {1'b0, mb};

  assign prod   = {acc[WIDTH-1:0], q};
  assign prod_f = neg_q ? -prod : prod;
  assign quo    = neg_q ? -q : q;
  assign rem    = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      dbz    <= 1'b0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      zero_b <= 1'b0;
      a_r    <= '0;
      mb     <= '0;
      q      <= '0;
      acc    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (accept) begin
            dbz    <= 1'b0;
            a_r    <= a;
            is_div <= op[1];
            neg_q  <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= sgn_op & a[WIDTH-1];
            zero_b <= (b == '0);
            mb     <= op[1] ? abs_b : abs_a;
            q      <= op[1] ? abs_a : abs_b;
            acc    <= '0;
            cnt    <= CW'(WIDTH - 1);
            unique case (op)
              3'b000, 3'b001,
              3'b010, 3'b011: state <= CALC;
              3'b100: begin
                hi    <= a;
                state <= DONE;
              end
              3'b101: begin
                lo    <= a;
                state <= DONE;
              end
              default: state <= IDLE;
            endcase
          end
        end
        CALC: begin
          if (is_div) begin
            if (!trial[WIDTH]) begin
              acc <= trial;
              q   <= {q[WIDTH-2:0], 1'b1};
            end else begin
              acc <= shl;
              q   <= {q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= {1'b0, add_sum[WIDTH:1]};
            q   <= {add_sum[0], q[WIDTH-1:1]};
          end
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          state <= DONE;
          if (!is_div) begin
            {hi, lo} <= prod_f;
          end else if (zero_b) begin
            hi  <= a_r;
            lo  <= '1;
            dbz <= 1'b1;
          end else begin
            hi <= rem;
            lo <= quo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: 32-bit and 8-bit instances.
// Expected values are hand-computed constants.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        ready8;
  logic        busy8;
  logic        done8;
  logic        dbz8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .a(a), .b(b), .ready(ready), .busy(busy), .done(done),
    .dbz(dbz), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .op(op8),
    .a(a8), .b(b8), .ready(ready8), .busy(busy8), .done(done8),
    .dbz(dbz8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one arithmetic op on the 32-bit unit and wait for done.
  task automatic run32(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, output int lat,
                       output int nbusy, output bit early);
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = hi;
    l0 = lo;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    lat   = 1;
    nbusy = 0;
    early = 1'b0;
    while (!done && lat < 200) begin
      if (busy) nbusy++;
      if (hi !== h0 || lo !== l0) early = 1'b1;
      tick();
      lat++;
    end
  endtask

  int lat;
  int nb;
  bit early;
  int pulses;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 3'b000;
    a       = '0;
    b       = '0;
    start8  = 1'b0;
    op8     = 3'b000;
    a8      = '0;
    b8      = '0;
    repeat (3) tick();
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(dbz), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst8_hilo", 64'({hi8, lo8, ready8, done8}), 64'h2);
    reset_n = 1'b1;
    tick();

    // signed multiply, -3 * 5
    run32(3'b000, 32'hFFFFFFFD, 32'h00000005, lat, nb, early);
    check("mult_lat", 64'(lat), 64'd34);
    check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    check("mult_early", 64'(early), 64'd0);
    check("mult_dbz", 64'(dbz), 64'd0);
    tick();
    check("done_pulse", 64'({done, ready}), 64'b01);
    check("hilo_hold", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);

    // unsigned full-width product
    run32(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, nb, early);
    check("multu_busy", 64'(nb), 64'd33);
    check("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

    // signed multiply, negative * negative
    run32(3'b000, 32'hFFFFFFFF, 32'h80000000, lat, nb, early);
    check("mult_nn", {hi, lo}, 64'h00000000_80000000);

    // -7 / 2 = -3 rem -1
    run32(3'b010, 32'hFFFFFFF9, 32'h00000002, lat, nb, early);
    check("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    check("div_lat", 64'(lat), 64'd34);

    // 7 / -2 = -3 rem 1
    run32(3'b010, 32'h00000007, 32'hFFFFFFFE, lat, nb, early);
    check("div_pn", {hi, lo}, 64'h00000001_FFFFFFFD);

    // unsigned divide, large dividend
    run32(3'b011, 32'hFFFFFFF9, 32'h00000010, lat, nb, early);
    check("divu_hilo", {hi, lo}, 64'h00000009_0FFFFFFF);

    // divide by zero
    run32(3'b011, 32'h00000007, 32'h00000000, lat, nb, early);
    check("dbz_lat", 64'(lat), 64'd34);
    check("dbz_hilo", {hi, lo}, 64'h00000007_FFFFFFFF);
    check("dbz_flag", 64'(dbz), 64'd1);
    tick();
    check("dbz_held", 64'(dbz), 64'd1);

    // signed overflow case
    run32(3'b010, 32'h80000000, 32'hFFFFFFFF, lat, nb, early);
    check("ovf_hilo", {hi, lo}, 64'h00000000_80000000);
    check("ovf_dbz", 64'(dbz), 64'd0);
    tick();

    // MTHI: done pulse on the next cycle, lo untouched
    start = 1'b1;
    op    = 3'b100;
    a     = 32'h12345678;
    tick();
    start = 1'b0;
    check("mthi_st", 64'({done, busy}), 64'b10);
    check("mthi_hilo", {hi, lo}, 64'h12345678_80000000);
    tick();
    check("mthi_end", 64'({done, busy, ready}), 64'b001);

    // reserved op is dropped
    start = 1'b1;
    op    = 3'b111;
    a     = 32'hAAAAAAAA;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    check("rsv_quiet", 64'(pulses), 64'd0);
    check("rsv_hilo", {hi, lo}, 64'h12345678_80000000);

    // start while busy is ignored, then reset mid-operation
    start = 1'b1;
    op    = 3'b001;
    a     = 32'd6;
    b     = 32'd7;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    op    = 3'b100;
    a     = 32'h0000DEAD;
    tick();
    start = 1'b0;
    check("ign_busy", 64'({busy, ready}), 64'b10);
    check("ign_hi", 64'(hi), 64'h12345678);
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_st", 64'({ready, busy, done}), 64'b100);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) pulses++;
      tick();
    end
    check("abort_nodone", 64'(pulses), 64'd0);
    check("abort_hilo2", {hi, lo}, 64'd0);

    // 8-bit: MTLO, then DIVU accepted back-to-back from DONE
    start8 = 1'b1;
    op8    = 3'b101;
    a8     = 8'h5A;
    tick();
    check("w8_mtlo", 64'({done8, lo8, hi8}), 64'h15A00);
    op8 = 3'b011;
    a8  = 8'hC8;
    b8  = 8'h0A;
    tick();
    start8 = 1'b0;
    lat    = 1;
    while (!done8 && lat < 100) begin
      tick();
      lat++;
    end
    check("w8_lat", 64'(lat), 64'd10);
    check("w8_divu", 64'({hi8, lo8}), 64'h0014);
    check("w8_dbz", 64'(dbz8), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
